// File: rtl/mul_share_pkg.sv
// Shared types and default sizing for the shared shift-add multiplier arbiter.
package mul_share_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Sequential shift-add multiplier datapath: one operand bit per cycle while i_run is high.
module mul_shift_add_core
  import mul_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_run,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_last_step
);

  localparam int STEP_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_a_sh;
  logic [2*WIDTH-1:0] r_b_sh;
  logic [2*WIDTH-1:0] r_acc;
  logic [STEP_W-1:0]  r_step;

  // r_step counts down the remaining steps; the last step is at terminal count zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_step <= '0;
    end else if (i_start) begin
      r_a_sh <= i_a;
      r_b_sh <= {{WIDTH{1'b0}}, i_b};
      r_acc  <= '0;
      r_step <= STEP_W'(WIDTH - 1);
    end else if (i_run) begin
      if (r_a_sh[0]) begin
        r_acc <= r_acc + r_b_sh;
      end
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh << 1;
      r_step <= r_step - 1'b1;
    end
  end

  assign o_acc       = r_acc;
  assign o_last_step = i_run && (r_step == '0);

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier core between NUM_REQ requesters.
//   state | meaning
//   IDLE  | offer grant to first valid requester at/after rr_ptr
//   RUN   | core performs WIDTH shift-add steps
//   DONE  | product presented until rsp handshake
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic [2*WIDTH-1:0]         o_rsp_product,
  output logic                       o_busy
);

  mul_state_e         r_state;
  mul_state_e         w_state_next;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_grant_any;
  int                 w_best_dist;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_start;
  logic               w_run;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_last_step;

  // Pick the valid requester with the smallest cyclic distance from rr_ptr.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req_valid[i] && (((i - int'(r_rr_ptr) + NUM_REQ) % NUM_REQ) < w_best_dist)) begin
        w_best_dist = (i - int'(r_rr_ptr) + NUM_REQ) % NUM_REQ;
        w_grant_id  = ID_W'(i);
        w_grant_any = 1'b1;
      end
    end
  end

  assign w_sel_a = i_req_a[int'(w_grant_id)*WIDTH +: WIDTH];
  assign w_sel_b = i_req_b[int'(w_grant_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_run        = 1'b0;
    w_ready      = '0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_any) begin
          w_ready[w_grant_id] = !rst;
          w_start             = 1'b1;
          w_state_next        = RUN;
        end
      end
      RUN: begin
        w_run = 1'b1;
        if (w_last_step) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (i_rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
    end else if (r_state == IDLE && w_grant_any) begin
      r_id     <= w_grant_id;
      r_rr_ptr <= (int'(w_grant_id) == NUM_REQ - 1) ? '0 : w_grant_id + 1'b1;
    end
  end

  mul_shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_run       (w_run),
    .i_a         (w_sel_a),
    .i_b         (w_sel_b),
    .o_acc       (w_acc),
    .o_last_step (w_last_step)
  );

  assign o_req_ready   = w_ready;
  assign o_rsp_valid   = (r_state == DONE);
  assign o_rsp_id      = r_id;
  assign o_rsp_product = w_acc;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: directed vectors plus a small random pass.
module tb_mul_share_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   i_req_valid;
  logic [NR-1:0]   o_req_ready;
  logic [NR*W-1:0] i_req_a;
  logic [NR*W-1:0] i_req_b;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [1:0]      o_rsp_id;
  logic [2*W-1:0]  o_rsp_product;
  logic            o_busy;

  mul_share_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_a       (i_req_a),
    .i_req_b       (i_req_b),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_product (o_rsp_product),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     id;
    longint prod;
  } exp_t;

  exp_t   sb[$];
  int     gq[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     rise_cyc = 0;
  logic   prev_valid = 1'b0;
  logic   prev_stall = 1'b0;
  logic [2*W-1:0] held_prod = '0;
  logic [1:0]     held_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    chk($countones(o_req_ready) <= 1, "ready_onehot", longint'(o_req_ready), 0);
    if (rst) begin
      chk(o_req_ready == '0, "ready_in_reset", longint'(o_req_ready), 0);
      gq.delete();
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (o_busy) chk(o_req_ready == '0, "ready_while_busy", longint'(o_req_ready), 0);
      if ((o_req_ready & i_req_valid) != '0) gq.push_back(cyc);
      if (o_rsp_valid && !prev_valid) rise_cyc = cyc;
      if (o_rsp_valid && prev_stall) begin
        chk(o_rsp_product == held_prod, "stall_product", longint'(o_rsp_product), longint'(held_prod));
        chk(o_rsp_id == held_id, "stall_id", longint'(o_rsp_id), longint'(held_id));
      end
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_rsp", longint'(o_rsp_product), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(o_rsp_product == e.prod[2*W-1:0], "product", longint'(o_rsp_product), e.prod);
          chk(int'(o_rsp_id) == e.id, "rsp_id", longint'(o_rsp_id), e.id);
        end
        if (gq.size() == 0) chk(1'b0, "latency_no_grant", rise_cyc, -1);
        else begin
          int g;
          g = gq.pop_front();
          chk(rise_cyc - g == 9, "latency", rise_cyc - g, 9);
        end
      end
      prev_valid = o_rsp_valid;
      prev_stall = o_rsp_valid && !i_rsp_ready;
      held_prod  = o_rsp_product;
      held_id    = o_rsp_id;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input int a, input int b, input bit push);
    exp_t e;
    sync();
    i_req_a[id*W +: W] = W'(a);
    i_req_b[id*W +: W] = W'(b);
    i_req_valid[id]    = 1'b1;
    if (push) begin
      e.id   = id;
      e.prod = longint'(a) * longint'(b);
      sb.push_back(e);
    end
  endtask

  task automatic wait_grant(input int id);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (o_req_ready[id]) got = 1'b1;
    end
    if (!got) chk(1'b0, "grant_timeout", id, id);
    sync();
    i_req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy) done = 1'b1;
    end
    if (!done) begin
      chk(1'b0, "idle_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  int ta[4] = '{5, 25, 45, 65};
  int tb[4] = '{7, 37, 67, 97};
  int tp[4] = '{35, 925, 3015, 6305};
  int rq[3] = '{0, 1, 3};

  initial begin
    int ngr;
    bit vis;
    rst = 1'b1;
    i_req_valid = 4'b0001;
    i_req_a = '0;
    i_req_b = '0;
    i_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(o_rsp_valid == 1'b0, "reset_rsp_valid", o_rsp_valid, 0);
    chk(o_rsp_id == '0, "reset_rsp_id", o_rsp_id, 0);
    chk(o_rsp_product == '0, "reset_product", o_rsp_product, 0);
    chk(o_busy == 1'b0, "reset_busy", o_busy, 0);
    sync();
    rst = 1'b0;
    i_req_valid = '0;

    // 1: full-scale product, same-cycle grant
    issue(0, 255, 255, 1'b1);
    @(negedge clk);
    chk(o_req_ready == 4'b0001, "t1_ready_same_cycle", o_req_ready, 1);
    sync();
    i_req_valid[0] = 1'b0;
    wait_idle();

    // 2: requester 2, then a zero operand
    issue(2, 13, 1, 1'b1);
    wait_grant(2);
    issue(2, 0, 200, 1'b1);
    wait_grant(2);
    wait_idle();

    // rr_ptr wrap 3 -> 0, then 8 back-to-back contended operations
    issue(3, 11, 11, 1'b1);
    wait_grant(3);
    wait_idle();
    sync();
    for (int i = 0; i < NR; i++) begin
      i_req_a[i*W +: W] = W'(ta[i]);
      i_req_b[i*W +: W] = W'(tb[i]);
    end
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.id = k % NR;
      e.prod = tp[k % NR];
      sb.push_back(e);
    end
    i_req_valid = 4'b1111;
    ngr = 0;
    for (int n = 0; n < 300 && ngr < 8; n++) begin
      @(negedge clk);
      if ((o_req_ready & i_req_valid) != '0) ngr++;
    end
    chk(ngr == 8, "t3_grant_count", ngr, 8);
    sync();
    i_req_valid = '0;
    wait_idle();

    // 4: downstream stall with a competing request pending
    sync();
    i_rsp_ready = 1'b0;
    issue(1, 100, 3, 1'b1);
    wait_grant(1);
    issue(3, 7, 9, 1'b1);
    vis = 1'b0;
    for (int n = 0; n < 50 && !vis; n++) begin
      @(negedge clk);
      if (o_rsp_valid) vis = 1'b1;
    end
    chk(vis, "t4_rsp_seen", vis, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk(o_req_ready == '0, "t4_stall_ready", o_req_ready, 0);
      chk(o_rsp_valid == 1'b1, "t4_stall_valid", o_rsp_valid, 1);
    end
    sync();
    i_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(o_req_ready == 4'b1000, "t4_grant_after_stall", o_req_ready, 8);
    sync();
    i_req_valid[3] = 1'b0;
    wait_idle();

    // 5: reset at RUN step 4 drops the operation and resets rr_ptr
    issue(2, 50, 50, 1'b0);
    wait_grant(2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk(o_rsp_valid == 1'b0, "t5_rsp_valid", o_rsp_valid, 0);
    chk(o_busy == 1'b0, "t5_busy", o_busy, 0);
    chk(o_rsp_product == '0, "t5_product", o_rsp_product, 0);
    issue(3, 4, 5, 1'b0);
    i_req_a[0 +: W] = 8'd6;
    i_req_b[0 +: W] = 8'd7;
    i_req_valid[0] = 1'b1;
    sb.push_back('{0, 42});
    sb.push_back('{3, 20});
    wait_grant(0);
    wait_grant(3);
    wait_idle();

    // 6: random operands on requesters 0, 1, 3 against a*b
    for (int k = 0; k < 12; k++) begin
      int id;
      int a;
      int b;
      id = rq[$urandom_range(0, 2)];
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      issue(id, a, b, 1'b1);
      wait_grant(id);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
